io_mmio_ctrl: RTL and testbench

// Memory-mapped I/O controller downstream of the core's load/store stage (addr[31:28]==4'h8).

---
 rtl/io_mmio_pkg.sv | 27 ++
 rtl/io_mmio_ctrl_if.sv | 36 +++
 rtl/io_sync_fifo.sv | 66 ++++++
 rtl/io_mmio_ctrl.sv | 155 +++++++++++++++
 tb/tb_io_mmio_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_mmio_pkg.sv
// Shared definitions for the memory-mapped I/O controller: region nibble,
// register offsets, TX state encoding and the status-word packer.
package io_mmio_pkg;

  // Upper address nibble of the I/O region (decoded by the core, not here)
  localparam logic [3:0] IO_REGION  = 4'h8;

  // Register offsets within the region (addr[7:0])
  localparam logic [7:0] IO_STATUS  = 8'h00;
  localparam logic [7:0] IO_RX      = 8'h04;
  localparam logic [7:0] IO_TX      = 8'h08;
  localparam logic [7:0] IO_CYC     = 8'h10;
  localparam logic [7:0] IO_INST    = 8'h14;
  localparam logic [7:0] IO_CNT_RST = 8'h18;

  // TX holding-register state: idle (can accept a store) or pending handshake
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PEND = 1'b1
  } tx_state_e;

  // Status register layout: {30'b0, rx_avail, tx_ready}
  function automatic logic [31:0] status_word(input logic rx_avail, input logic tx_ready);
    return {30'b0, rx_avail, tx_ready};
  endfunction

endpackage

// File: rtl/io_mmio_ctrl_if.sv
// Bus bundle between the core load/store stage, the UART ports and the
// I/O controller. The master side is the core/UART environment, the slave
// side is io_mmio_ctrl.
interface io_mmio_ctrl_if;

  // CPU load/store side
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_rdata;
  logic        inst_retire;

  // uart_receiver side
  logic [7:0]  uart_rx_data_out;
  logic        uart_rx_data_out_valid;
  logic        uart_rx_data_out_ready;

  // uart_transmitter side
  logic [7:0]  uart_tx_data_in;
  logic        uart_tx_data_in_valid;
  logic        uart_tx_data_in_ready;

  modport master (
    output io_addr, io_wdata, io_we, io_re, inst_retire,
    output uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
    input  io_rdata, uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
  );

  modport slave (
    input  io_addr, io_wdata, io_we, io_re, inst_retire,
    input  uart_rx_data_out, uart_rx_data_out_valid, uart_tx_data_in_ready,
    output io_rdata, uart_rx_data_out_ready, uart_tx_data_in, uart_tx_data_in_valid
  );

endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with registered read/write pointers and occupancy count.
// Push is ignored when full and pop is ignored when empty; a simultaneous
// push and pop leaves the count unchanged. DEPTH must be a power of two so
// the pointers wrap naturally.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// Memory-mapped I/O controller: decodes addr[7:0] of the I/O region,
// buffers UART RX bytes in a small FIFO, holds one pending TX byte until the
// transmitter accepts it, and provides cycle / retired-instruction counters.
// Loads return registered data one cycle after io_re, like dmem/bios_mem.
module io_mmio_ctrl
  import io_mmio_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  io_mmio_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(RX_FIFO_DEPTH) + 1;

  // Address decode
  logic [7:0]       w_off;
  logic             w_wr_tx;
  logic             w_wr_cnt_rst;
  logic             w_rd_rx;

  // RX FIFO
  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic [7:0]       w_fifo_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;

  // TX holding register
  tx_state_e        r_tx_state;
  tx_state_e        w_tx_state_next;
  logic             w_tx_load;
  logic [7:0]       r_tx_data;
  logic             w_tx_ready;

  // Counters and read path
  logic [31:0]      r_cycle_cnt;
  logic [31:0]      r_inst_cnt;
  logic [31:0]      r_rdata;
  logic [31:0]      w_rdata_next;

  // Upper address/data bits and the FIFO count are not needed here; the core
  // gates the region and only the low data byte goes to the transmitter.
  logic             w_unused;
  assign w_unused = ^{bus.io_addr[31:8], bus.io_wdata[31:8], w_fifo_count};

  assign w_off        = bus.io_addr[7:0];
  assign w_wr_tx      = bus.io_we && (w_off == IO_TX);
  assign w_wr_cnt_rst = bus.io_we && (w_off == IO_CNT_RST);
  assign w_rd_rx      = bus.io_re && (w_off == IO_RX);

  // A receiver byte is taken whenever there is room; a pop only happens when
  // a load of the RX register finds data.
  assign w_fifo_push  = bus.uart_rx_data_out_valid && !w_fifo_full;
  assign w_fifo_pop   = w_rd_rx && !w_fifo_empty;

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_data  (bus.uart_rx_data_out),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.uart_rx_data_out_ready = !w_fifo_full;

  // TX state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_state_next;
    end
  end

  // TX next state: accept a store only when idle, release after handshake
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_load       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_wr_tx) begin
          w_tx_state_next = TX_PEND;
          w_tx_load       = 1'b1;
        end
      end
      TX_PEND: begin
        if (bus.uart_tx_data_in_ready) begin
          w_tx_state_next = TX_IDLE;
        end
      end
      default: w_tx_state_next = TX_IDLE;
    endcase
  end

  // TX data byte: captured on an accepted store, otherwise held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_data <= '0;
    end else if (w_tx_load) begin
      r_tx_data <= bus.io_wdata[7:0];
    end
  end

  assign w_tx_ready                = (r_tx_state == TX_IDLE);
  assign bus.uart_tx_data_in       = r_tx_data;
  assign bus.uart_tx_data_in_valid = (r_tx_state == TX_PEND);

  // Free-running counters; a counter-reset store wins over the increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else if (w_wr_cnt_rst) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      r_inst_cnt  <= r_inst_cnt + {31'b0, bus.inst_retire};
    end
  end

  // Load data mux; all sources are pre-update values of this cycle
  always_comb begin
    w_rdata_next = '0;
    case (w_off)
      IO_STATUS: w_rdata_next = status_word(!w_fifo_empty, w_tx_ready);
      IO_RX:     w_rdata_next = w_fifo_empty ? 32'd0 : {24'b0, w_fifo_head};
      IO_CYC:    w_rdata_next = r_cycle_cnt;
      IO_INST:   w_rdata_next = r_inst_cnt;
      default:   w_rdata_next = '0;
    endcase
  end

  // Registered load data, held until the next load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (bus.io_re) begin
      r_rdata <= w_rdata_next;
    end
  end

  assign bus.io_rdata = r_rdata;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Scoreboard bench for io_mmio_ctrl: stimulus tasks push expected load data
// from a queue/counter reference model; a monitor compares io_rdata.
module tb_io_mmio_ctrl;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_mmio_ctrl_if bus ();

  io_mmio_ctrl #(.RX_FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q [$];

  // Reference model state
  logic [7:0]  m_fifo [$];
  logic [31:0] m_cyc;
  logic [31:0] m_inst;
  bit          m_tx_pend;
  logic [7:0]  m_tx_data;

  logic        mon_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      8'h00: return {30'b0, (m_fifo.size() != 0), !m_tx_pend};
      8'h04: return (m_fifo.size() != 0) ? {24'b0, m_fifo[0]} : 32'd0;
      8'h10: return m_cyc;
      8'h14: return m_inst;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_cyc     = 32'd0;
    m_inst    = 32'd0;
    m_tx_pend = 1'b0;
    m_tx_data = 8'd0;
  endtask

  // One clock edge of behaviour, using the inputs presented this cycle
  task automatic model_update();
    logic [7:0] off;
    bit room;
    off  = bus.io_addr[7:0];
    room = (m_fifo.size() < DEPTH);
    if (bus.io_re && off == 8'h04 && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (bus.uart_rx_data_out_valid && room) m_fifo.push_back(bus.uart_rx_data_out);
    if (m_tx_pend) begin
      if (bus.uart_tx_data_in_ready) m_tx_pend = 1'b0;
    end else if (bus.io_we && off == 8'h08) begin
      m_tx_pend = 1'b1;
      m_tx_data = bus.io_wdata[7:0];
    end
    if (bus.io_we && off == 8'h18) begin
      m_cyc  = 32'd0;
      m_inst = 32'd0;
    end else begin
      m_cyc  = m_cyc + 32'd1;
      m_inst = m_inst + (bus.inst_retire ? 32'd1 : 32'd0);
    end
  endtask

  // Advance one cycle with the current inputs, then check handshake outputs
  task automatic step();
    if (bus.io_re) exp_q.push_back(model_read(bus.io_addr[7:0]));
    model_update();
    @(posedge clk);
    #1;
    check("rx_ready", {31'b0, bus.uart_rx_data_out_ready}, {31'b0, (m_fifo.size() < DEPTH)});
    check("tx_valid", {31'b0, bus.uart_tx_data_in_valid}, {31'b0, m_tx_pend});
    check("tx_data", {24'b0, bus.uart_tx_data_in}, {24'b0, m_tx_data});
  endtask

  task automatic set_addr(input logic [7:0] off);
    bus.io_addr = {4'h8, 20'($urandom), off};
  endtask

  task automatic rd(input logic [7:0] off);
    set_addr(off);
    bus.io_re = 1'b1;
    step();
    bus.io_re = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    set_addr(off);
    bus.io_wdata = data;
    bus.io_we = 1'b1;
    step();
    bus.io_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_tx_valid", {31'b0, bus.uart_tx_data_in_valid}, 32'd0);
    check("rst_rx_ready", {31'b0, bus.uart_rx_data_out_ready}, 32'd1);
    check("rst_rdata", bus.io_rdata, 32'd0);
    check("rst_tx_data", {24'b0, bus.uart_tx_data_in}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: a load sampled at an edge is compared on the following negedge
  initial begin
    forever begin
      @(posedge clk);
      mon_pend = bus.io_re && !rst;
      @(negedge clk);
      if (mon_pend) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rdata: got %h expected <none queued>", bus.io_rdata);
        end else begin
          check("rdata", bus.io_rdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] offs [8];
    logic [7:0] off;
    offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h0C, 8'h1C};

    bus.io_addr = 32'h8000_0000;
    bus.io_wdata = 32'd0;
    bus.io_we = 1'b0;
    bus.io_re = 1'b0;
    bus.inst_retire = 1'b0;
    bus.uart_rx_data_out = 8'd0;
    bus.uart_rx_data_out_valid = 1'b0;
    bus.uart_tx_data_in_ready = 1'b1;

    // Reset and cycle counter start
    do_reset();
    repeat (5) step();
    rd(8'h10);

    // Two RX bytes, status, three pops (last on empty)
    bus.uart_rx_data_out_valid = 1'b1;
    bus.uart_rx_data_out = 8'h41; step();
    bus.uart_rx_data_out = 8'h42; step();
    bus.uart_rx_data_out_valid = 1'b0;
    rd(8'h00);
    rd(8'h04);
    rd(8'h04);
    rd(8'h04);

    // Fill the FIFO, hold a fifth byte while full, release with a pop
    bus.uart_rx_data_out_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.uart_rx_data_out = 8'h10 + 8'(i);
      step();
    end
    bus.uart_rx_data_out = 8'h14;
    repeat (3) step();
    rd(8'h04);
    step();
    bus.uart_rx_data_out_valid = 1'b0;
    for (int i = 0; i < 5; i++) rd(8'h04);

    // TX held while transmitter busy; second store dropped
    bus.uart_tx_data_in_ready = 1'b0;
    wr(8'h08, 32'h0000_0055);
    repeat (3) step();
    wr(8'h08, 32'h0000_0066);
    rd(8'h00);
    bus.uart_tx_data_in_ready = 1'b1;
    step();
    rd(8'h00);
    wr(8'h08, 32'hABCD_EF77);
    step();

    // Retired-instruction counter and counter reset beating an increment
    bus.inst_retire = 1'b1;
    repeat (10) step();
    bus.inst_retire = 1'b0;
    rd(8'h14);
    bus.inst_retire = 1'b1;
    wr(8'h18, 32'h1234_5678);
    bus.inst_retire = 1'b0;
    rd(8'h14);
    rd(8'h10);

    // Load and store in the same cycle to different behaviour
    set_addr(8'h08);
    bus.io_wdata = 32'h0000_0099;
    bus.io_we = 1'b1;
    bus.io_re = 1'b1;
    step();
    bus.io_we = 1'b0;
    bus.io_re = 1'b0;
    rd(8'h0C);

    // Cycle counter wrap
    force dut.r_cycle_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.r_cycle_cnt;
    m_cyc = 32'hFFFF_FFFD;
    repeat (5) rd(8'h10);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      off = offs[$urandom_range(0, 7)];
      bus.io_re = 1'($urandom_range(0, 1));
      bus.io_we = ($urandom_range(0, 3) == 0);
      if (off == 8'h18 && bus.io_we && $urandom_range(0, 7) != 0) off = 8'h10;
      set_addr(off);
      bus.io_wdata = $urandom;
      bus.uart_rx_data_out = 8'($urandom);
      bus.uart_rx_data_out_valid = 1'($urandom_range(0, 1));
      bus.uart_tx_data_in_ready = ($urandom_range(0, 2) == 0);
      bus.inst_retire = 1'($urandom_range(0, 1));
      step();
    end
    bus.io_re = 1'b0;
    bus.io_we = 1'b0;
    bus.uart_rx_data_out_valid = 1'b0;
    bus.inst_retire = 1'b0;

    // Reset while a TX byte is pending and RX data is buffered
    bus.uart_tx_data_in_ready = 1'b0;
    bus.uart_rx_data_out_valid = 1'b1;
    bus.uart_rx_data_out = 8'h5A;
    step();
    bus.uart_rx_data_out_valid = 1'b0;
    wr(8'h08, 32'h0000_00C3);
    step();
    do_reset();
    bus.uart_tx_data_in_ready = 1'b1;
    rd(8'h00);
    rd(8'h04);
    rd(8'h10);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
